tetris_sched: RTL
=================

# tetris_sched

Game sequencer for the 12×12 Tetris playfield. It owns the order in which the playfield datapath may change state. It turns the gravity timer, the debounced buttons, and the datapath's feasibility and full-row flags into a stream of single-cycle commands: spawn, fall, lock, shift, rotate and clear-row. The block sits between the `pbdebounce` instances and the playfield register logic, and replaces the ad-hoc `clk_div` slot decoding.

## Interface
Parameters:
- `FALL_DIV`, 67108864: gravity period in `clk` cycles; must be ≥ 2.
- `MOVE_DIV`, 8388608: shift auto-repeat period in cycles while a shift button is held; must be ≥ 2.

Ports (clock and reset first):
- `clk` in 1: 100 MHz system clock. One clock only.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: level; leaves IDLE.
- `btn_left_n`, `btn_right_n`, `btn_rot_l_n`, `btn_rot_r_n` in 1 each: debounced buttons, active-low.
- `can_fall`, `can_left`, `can_right`, `can_rot_l`, `can_rot_r` in 1 each: the datapath reports the move is legal for the current piece.
- `spawn_ok` in 1: the next piece does not overlap `occupy`.
- `full_rows` in 12: bit r set means row r is full (row 0 is the top row).
- `cmd_valid` out 1: command strobe, one cycle wide.
- `cmd_op` out 3: 0 SPAWN, 1 FALL, 2 LOCK, 3 LEFT, 4 RIGHT, 5 ROT_L, 6 ROT_R, 7 CLEAR.
- `cmd_row` out 4: row to clear; meaningful only with CLEAR.
- `state` out 3: 0 IDLE, 1 SPAWN, 2 PLAY, 3 CLEAR, 4 OVER.
- `lose` out 1: game over.
- `lines` out 16: number of rows cleared.

## Operation
- All outputs are registered.
- Reset values:
  - `state`=IDLE.
  - `cmd_valid`=0, `cmd_op`=0, `cmd_row`=0.
  - `lose`=0, `lines`=0.
  - Gravity counter, repeat counter, pending flags and button history registers all 0.
- Gap rule: every command is followed by at least one cycle with `cmd_valid`=0. Feasibility inputs and `full_rows` are sampled only in such gap cycles.
- IDLE:
  - `start`=1 clears `lines` and moves to SPAWN.
  - Button edges in IDLE are ignored.
- SPAWN (one decision cycle):
  - `spawn_ok`=1: issue SPAWN, zero the gravity counter, clear all pending flags, go to PLAY.
  - `spawn_ok`=0: set `lose`, go to OVER.
- PLAY, gravity:
  - The gravity counter runs 0..`FALL_DIV`-1.
  - On wrap it sets `fall_pend`.
- PLAY, buttons:
  - A press is a 1→0 transition of a button (compared against its registered previous value). A press sets that button's pending flag.
  - While left or right is held, a repeat counter re-sets the corresponding flag every `MOVE_DIV` cycles after the press.
  - Rotations do not repeat.
- PLAY, arbitration (only in gap cycles, one command at most):
  1. ROT_L has highest priority. If both rotation flags are pending, ROT_L wins and `rot_r_pend` is cleared.
  2. ROT_R is next.
  3. Shifts come next. If LEFT and RIGHT are both pending, both are cleared and nothing is issued. Otherwise the single pending shift is taken.
  4. FALL has lowest priority.
- PLAY, issuing a command:
  - The chosen flag is cleared.
  - If the matching `can_*` is 0, nothing is issued.
  - A fall with `can_fall`=0 issues LOCK instead and moves to CLEAR.
- CLEAR:
  - Pending flags are held at 0 and the gravity counter is frozen.
  - In each gap cycle, if `full_rows`≠0: issue CLEAR with `cmd_row` = highest set index (the bottom-most full row). Increment `lines`, saturating at 0xFFFF.
  - If `full_rows`=0: go to SPAWN.
- OVER:
  - Terminal state; only `rst` leaves it.
  - `lose` stays 1 and `cmd_valid` stays 0.
- `rst` asserted mid-command or mid-clear: all registers return to reset values at that edge. An in-flight command is not repeated.

## Timing
- Command latency:
  - A button press sampled at edge N produces `cmd_valid` at edge N+1 at the earliest, if a gap cycle is available.
  - A gravity wrap produces FALL one cycle later under the same condition.
- The datapath applies a command on the edge that ends its `cmd_valid` cycle. Status inputs reflect the new state in the following gap cycle.
- LOCK at cycle T gives the first CLEAR decision at T+2. Each additional full row costs 2 cycles.
- Spawn after a clear sequence occurs 2 cycles after the final `full_rows`=0 sample.
- Button activity and gravity wraps that occur during a `cmd_valid` cycle still set their flags. They are serviced in the next gap cycle.

## Test plan
- Start, then fall:
  - Stimulus: `FALL_DIV`=8, `spawn_ok`=1, `start` pulse.
  - Required: SPAWN once, `state`=2, FALL at 9 cycles after SPAWN, then every 8 cycles while `can_fall`=1.
- Press arbitration:
  - Stimulus: `btn_rot_l_n` and `btn_rot_r_n` fall in the same cycle, with `btn_left_n` also low.
  - Required: ROT_L, then LEFT two cycles later; no ROT_R.
- Shift conflict and auto-repeat:
  - Stimulus: left and right pressed together.
  - Required: no command.
  - Stimulus: left alone held 20 cycles with `MOVE_DIV`=4.
  - Required: LEFT at press+1, then one LEFT every 4 cycles.
- Lock and two-row clear:
  - Stimulus: `can_fall`=0 at gravity wrap, `full_rows`=0x0C0 then 0x040 then 0x000.
  - Required: LOCK, CLEAR row 7, CLEAR row 6, SPAWN. `lines`=2.
- Game over:
  - Stimulus: `spawn_ok`=0 at SPAWN.
  - Required: `lose`=1, `state`=4, no further commands under any button or `start` activity.
- Reset mid-clear:
  - Stimulus: `rst` during a CLEAR command cycle.
  - Required: next cycle `state`=0, `cmd_valid`=0, `lines`=0, `lose`=0.

Source files
------------

// File: rtl/tetris_sched.sv
// Game sequencer for the 12x12 Tetris playfield: turns gravity, buttons and datapath status
// into single-cycle playfield commands, each followed by at least one idle gap cycle.
module tetris_sched #(
    parameter int unsigned FALL_DIV = 67108864,
    parameter int unsigned MOVE_DIV = 8388608
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        btn_left_n,
    input  logic        btn_right_n,
    input  logic        btn_rot_l_n,
    input  logic        btn_rot_r_n,
    input  logic        can_fall,
    input  logic        can_left,
    input  logic        can_right,
    input  logic        can_rot_l,
    input  logic        can_rot_r,
    input  logic        spawn_ok,
    input  logic [11:0] full_rows,
    output logic        cmd_valid,
    output logic [2:0]  cmd_op,
    output logic [3:0]  cmd_row,
    output logic [2:0]  state,
    output logic        lose,
    output logic [15:0] lines
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSpawn = 3'd1;
    localparam logic [2:0] StPlay  = 3'd2;
    localparam logic [2:0] StClear = 3'd3;
    localparam logic [2:0] StOver  = 3'd4;

    localparam logic [2:0] OpSpawn = 3'd0;
    localparam logic [2:0] OpFall  = 3'd1;
    localparam logic [2:0] OpLock  = 3'd2;
    localparam logic [2:0] OpLeft  = 3'd3;
    localparam logic [2:0] OpRight = 3'd4;
    localparam logic [2:0] OpRotL  = 3'd5;
    localparam logic [2:0] OpRotR  = 3'd6;
    localparam logic [2:0] OpClear = 3'd7;

    localparam int unsigned FallW = $clog2(FALL_DIV);
    localparam int unsigned MoveW = $clog2(MOVE_DIV);
    localparam logic [FallW-1:0] FallMax = FallW'(FALL_DIV - 1);
    localparam logic [MoveW-1:0] MoveMax = MoveW'(MOVE_DIV - 1);

    // Pending-flag and button vector bit positions.
    localparam int unsigned PFall  = 0;
    localparam int unsigned PLeft  = 1;
    localparam int unsigned PRight = 2;
    localparam int unsigned PRotL  = 3;
    localparam int unsigned PRotR  = 4;
    localparam int unsigned BLeft  = 0;
    localparam int unsigned BRight = 1;
    localparam int unsigned BRotL  = 2;
    localparam int unsigned BRotR  = 3;

    logic [2:0]       state_q, state_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [2:0]       cmd_op_q, cmd_op_d;
    logic [3:0]       cmd_row_q, cmd_row_d;
    logic             lose_q, lose_d;
    logic [15:0]      lines_q, lines_d;
    logic [FallW-1:0] fall_cnt_q, fall_cnt_d;
    logic [MoveW-1:0] move_cnt_q, move_cnt_d;
    logic [4:0]       pend_q, pend_d;
    logic [3:0]       btn_prev_q, btn_prev_d;

    logic [3:0] btn_now, press, held;
    logic [4:0] pend_set, pend_clr;
    logic       gap, flush, issue, fall_wrap, rpt_fire;
    logic [2:0] op;
    logic [3:0] top_row;

    always_comb begin
        btn_now     = {btn_rot_r_n, btn_rot_l_n, btn_right_n, btn_left_n};
        press       = btn_prev_q & ~btn_now;
        held        = ~btn_prev_q & ~btn_now;
        btn_prev_d  = btn_now;
        gap         = ~cmd_valid_q;
        state_d     = state_q;
        cmd_valid_d = 1'b0;
        cmd_op_d    = cmd_op_q;
        cmd_row_d   = cmd_row_q;
        lose_d      = lose_q;
        lines_d     = lines_q;
        fall_cnt_d  = fall_cnt_q;
        move_cnt_d  = move_cnt_q;
        pend_set    = '0;
        pend_clr    = '0;
        flush       = 1'b0;
        issue       = 1'b0;
        fall_wrap   = 1'b0;
        rpt_fire    = 1'b0;
        op          = OpFall;
        top_row     = '0;
        // Later iterations win, so this yields the bottom-most full row.
        for (int r = 0; r < 12; r++) begin
            if (full_rows[r]) top_row = 4'(r);
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    lines_d = '0;
                    state_d = StSpawn;
                end
            end
            StSpawn: begin
                flush = 1'b1;
                if (spawn_ok) begin
                    issue      = 1'b1;
                    op         = OpSpawn;
                    fall_cnt_d = '0;
                    move_cnt_d = '0;
                    state_d    = StPlay;
                end else begin
                    lose_d  = 1'b1;
                    state_d = StOver;
                end
            end
            StPlay: begin
                if (fall_cnt_q == FallMax) begin
                    fall_cnt_d = '0;
                    fall_wrap  = 1'b1;
                end else begin
                    fall_cnt_d = fall_cnt_q + 1'b1;
                end
                // Auto-repeat phase restarts on every shift press.
                if (press[BLeft] || press[BRight] || !(held[BLeft] || held[BRight])) begin
                    move_cnt_d = '0;
                end else if (move_cnt_q == MoveMax) begin
                    move_cnt_d = '0;
                    rpt_fire   = 1'b1;
                end else begin
                    move_cnt_d = move_cnt_q + 1'b1;
                end
                pend_set = {press[BRotR], press[BRotL],
                            press[BRight] | (rpt_fire & held[BRight]),
                            press[BLeft] | (rpt_fire & held[BLeft]),
                            fall_wrap};
                if (gap) begin
                    if (pend_q[PRotL]) begin
                        pend_clr[PRotL] = 1'b1;
                        pend_clr[PRotR] = 1'b1;
                        issue           = can_rot_l;
                        op              = OpRotL;
                    end else if (pend_q[PRotR]) begin
                        pend_clr[PRotR] = 1'b1;
                        issue           = can_rot_r;
                        op              = OpRotR;
                    end else if (pend_q[PLeft] && pend_q[PRight]) begin
                        pend_clr[PLeft]  = 1'b1;
                        pend_clr[PRight] = 1'b1;
                    end else if (pend_q[PLeft]) begin
                        pend_clr[PLeft] = 1'b1;
                        issue           = can_left;
                        op              = OpLeft;
                    end else if (pend_q[PRight]) begin
                        pend_clr[PRight] = 1'b1;
                        issue            = can_right;
                        op               = OpRight;
                    end else if (pend_q[PFall]) begin
                        pend_clr[PFall] = 1'b1;
                        issue           = 1'b1;
                        if (can_fall) begin
                            op = OpFall;
                        end else begin
                            op      = OpLock;
                            flush   = 1'b1;
                            state_d = StClear;
                        end
                    end
                end
            end
            StClear: begin
                flush = 1'b1;
                if (gap) begin
                    if (|full_rows) begin
                        issue     = 1'b1;
                        op        = OpClear;
                        cmd_row_d = top_row;
                        if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
                    end else begin
                        state_d = StSpawn;
                    end
                end
            end
            StOver: begin
                lose_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (issue) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = op;
        end
        pend_d = flush ? '0 : ((pend_q & ~pend_clr) | pend_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_row_q   <= '0;
            lose_q      <= 1'b0;
            lines_q     <= '0;
            fall_cnt_q  <= '0;
            move_cnt_q  <= '0;
            pend_q      <= '0;
            btn_prev_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_row_q   <= cmd_row_d;
            lose_q      <= lose_d;
            lines_q     <= lines_d;
            fall_cnt_q  <= fall_cnt_d;
            move_cnt_q  <= move_cnt_d;
            pend_q      <= pend_d;
            btn_prev_q  <= btn_prev_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_row   = cmd_row_q;
    assign state     = state_q;
    assign lose      = lose_q;
    assign lines     = lines_q;

endmodule
